// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM sequencing fetch/decode/execute/memory/writeback for the ARM-subset datapath.
// Revision 1.0
`default_nettype none

module multicycle_controller #(
  parameter int ALU_CTRL_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [19:0]           Instr,
  input  logic [3:0]            ALUFlags,
  input  logic                  MemReady,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic [1:0]            ResultSrc,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [1:0]            ImmSrc,
  output logic [1:0]            RegSrc,
  output logic                  RegWrite,
  output logic                  Illegal,
  output logic [3:0]            State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;
  logic [2:0] dp_alu;
  logic       dp_legal;
  logic       is_cmp;
  logic       cond_ex;
  logic       illegal_enc;
  logic [2:0] alu_op;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign cmd       = funct[4:1];
  assign unused_rn = ^Instr[7:4];

  assign ImmSrc = op;
  assign RegSrc = {op == 2'b01, op == 2'b10};
  assign State  = state_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    dp_alu   = 3'b000;
    dp_legal = 1'b1;
    is_cmp   = 1'b0;
    case (cmd)
      4'b0100: dp_alu = 3'b000;
      4'b0010: dp_alu = 3'b001;
      4'b0000: dp_alu = 3'b010;
      4'b1100: dp_alu = 3'b011;
      4'b0001: dp_alu = 3'b100;
      4'b1101: dp_alu = 3'b101;
      4'b1010: begin
        dp_alu   = 3'b001;
        is_cmp   = 1'b1;
        dp_legal = funct[0];
      end
      default: dp_legal = 1'b0;
    endcase
  end

  // flags_q is {N, Z, C, V}; Cond=1111 is treated as passing so it reaches the illegal check
  always_comb begin
    cond_ex = 1'b1;
    case (cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = !flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = !flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = !flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = !flags_q[0];
      4'b1000: cond_ex = flags_q[1] && !flags_q[2];
      4'b1001: cond_ex = !flags_q[1] || flags_q[2];
      4'b1010: cond_ex = flags_q[3] == flags_q[0];
      4'b1011: cond_ex = flags_q[3] != flags_q[0];
      4'b1100: cond_ex = !flags_q[2] && (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] || (flags_q[3] != flags_q[0]);
      default: cond_ex = 1'b1;
    endcase
  end

  assign illegal_enc = (cond == 4'hF) || (op == 2'b11) || ((op == 2'b00) && !dp_legal);

  always_comb begin
    state_d   = state_q;
    flags_d   = flags_q;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    alu_op    = 3'b000;
    RegWrite  = 1'b0;
    Illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (!cond_ex) begin
          state_d = S_FETCH;
        end else if (illegal_enc) begin
          Illegal = 1'b1;
          state_d = S_FETCH;
        end else begin
          case (op)
            2'b01:   state_d = S_MEMADR;
            2'b10:   state_d = S_BRANCH;
            default: state_d = funct[5] ? S_EXECI : S_EXECR;
          endcase
        end
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        if (rd == 4'hF) PCWrite = 1'b1;
        else            RegWrite = 1'b1;
        state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        alu_op  = dp_alu;
        if (funct[0]) flags_d = ALUFlags;
        state_d = is_cmp ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        if (rd == 4'hF) PCWrite = 1'b1;
        else            RegWrite = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // strobes are suppressed for the whole time reset is held low
    if (!reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      Illegal  = 1'b0;
    end
    ALUControl      = '0;
    ALUControl[2:0] = alu_op;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multicycle control unit for the ARM-subset datapath: the next generation of the single-cycle `controller`. A state machine sequences fetch, decode, execute, memory and writeback over several cycles. Memory accesses use a `MemReady` wait-state handshake, so slow memories stall the sequence rather than break it. It evaluates condition codes against an internal NZCV register, sets flags on S-suffixed data-processing ops, and flags unsupported encodings.

## Interface
Parameters:
- `ALU_CTRL_W`, 3, width of `ALUControl`; must be ≥3; bits above [2:0] driven 0.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low.
- `Instr`  in  20  instruction bits [31:12]; Cond=[31:28], Op=[27:26], Funct=[25:20], Rd=[15:12].
- `ALUFlags`  in  4  NZCV from ALU, valid in EXECR/EXECI.
- `MemReady`  in  1  memory completes the current access this cycle.
- `PCWrite`  out  1  load PC.
- `AdrSrc`  out  1  0 = PC address, 1 = ALU-result address.
- `MemWrite`  out  1  store request.
- `IRWrite`  out  1  load instruction register.
- `ResultSrc`  out  2  00 ALUOut, 01 read data, 10 ALU result.
- `ALUSrcA`  out  1  0 = register A, 1 = PC.
- `ALUSrcB`  out  2  00 register B, 01 ExtImm, 10 constant 4.
- `ALUControl`  out  ALU_CTRL_W  operation select.
- `ImmSrc`  out  2  equals Op.
- `RegSrc`  out  2  [0] = (Op==10), [1] = (Op==01).
- `RegWrite`  out  1  register file write.
- `Illegal`  out  1  one-cycle pulse on an unsupported encoding.
- `State`  out  4  current state, for debug.

## Operation
- States, with encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9. Codes 10–15 go to FETCH.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, IRWrite=PCWrite=MemReady. Stay while MemReady=0; go to DECODE when it is 1.
- DECODE: ALUSrcA=1, ALUSrcB=10, ADD (forms PC+8). Evaluate Cond against the flag register.
  - CondEx=0 → FETCH.
  - Illegal encoding → assert Illegal, go to FETCH.
  - Op=01 → MEMADR.
  - Op=10 → BRANCH.
  - Op=00 with Funct[5]=1 → EXECI; Funct[5]=0 → EXECR.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Funct[0]=1 → MEMRD; 0 → MEMWR.
- MEMRD: AdrSrc=1. Hold while MemReady=0; when 1, go to MEMWB.
- MEMWR: AdrSrc=1, MemWrite=1. Hold while MemReady=0; when 1, go to FETCH.
- MEMWB: ResultSrc=01, then FETCH.
- EXECR: ALUSrcA=0, ALUSrcB=00, decoded op. EXECI is the same with ALUSrcB=01.
  - Both go to ALUWB, except CMP, which goes to FETCH.
  - If Funct[0]=1 (S bit), load ALUFlags into the flag register at the end of the cycle.
- ALUWB: ResultSrc=00, then FETCH.
- Writeback in MEMWB and ALUWB:
  - Rd≠15 → RegWrite=1.
  - Rd=15 → PCWrite=1 and RegWrite=0.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=1, then FETCH.
- Command mapping, Funct[4:1] → ALUControl[2:0]:
  - 0100 ADD → 000
  - 0010 SUB → 001
  - 0000 AND → 010
  - 1100 ORR → 011
  - 0001 EOR → 100
  - 1101 MOV → 101
  - 1010 CMP → 001; legal only with S=1, no writeback.
- Illegal encodings: any other command; CMP with S=0; Op=11; Cond=1111.
- Conditions: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE per ARM; AL (1110) is always true.
- Outputs not listed for a state are 0. ALUControl defaults to 000 (ADD).

## Timing
- Outputs are combinational from State and Instr (Moore plus instruction decode). Instr is held stable from DECODE to the end of the instruction.
- Reset=0 at an edge, from any state including mid-access: State→FETCH, flags→0000.
- While reset=0, force PCWrite, IRWrite, MemWrite, RegWrite and Illegal to 0.
- Instruction latencies with MemReady=1:
  - Data-processing: 4 cycles.
  - CMP: 3 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Branch taken: 3 cycles.
  - Any failed condition: 2 cycles.
- Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds one cycle. Request outputs stay asserted until the completing cycle.
- Flag update and CondEx evaluation never occur in the same cycle. DECODE always sees flags written by an earlier instruction.

## Test plan
- Reset: hold reset=0 for 2 cycles in state 5 with MemReady=0 → State=0, all strobes 0. Release with MemReady=1 → first cycle has PCWrite=IRWrite=1.
- ADD immediate, Instr=20'hE2802, MemReady=1 → State 0,1,7,8,0. ALUControl=000 and ALUSrcB=01 in EXECI. RegWrite=1 only in ALUWB.
- SUBS with ALUFlags=4'b0100, then BEQ 20'h0A000 → flags Z=1, BRANCH has PCWrite=1. Repeat with ALUFlags=0000 → DECODE→FETCH, PCWrite never asserted outside FETCH.
- LDR, Instr=20'hE5912, MemReady low for 3 cycles in MEMRD → MEMRD held 4 cycles with AdrSrc=1, then MEMWB with RegWrite=1. Same sequence with reset=0 during MEMRD → FETCH next cycle, no RegWrite.
- STR, Instr=20'hE5812 → MEMWR with MemWrite=1 held until MemReady=1, RegWrite never 1. ADD with Rd=15 (20'hE280F) → ALUWB drives PCWrite=1 and RegWrite=0.
- CMP, Instr=20'hE1500 → State 0,1,6,0 with ALUControl=001. RSB encoding 20'hE0600 → Illegal=1 for one cycle in DECODE, next state FETCH.
